or16_result_checker: RTL and testbench

- Hardware response checker for the 16-bit OR datapath; it is the capture/compare end of the exhaustive A/B stimulus sweep.
- Accepts one (A, B, OUT) sample per valid/ready handshake.
- Recomputes A|B, counts samples and mismatches, and latches the first failing sample.
- Reports PASS/FAIL when the programmed sample total is reached. Sits between the stimulus sequencer plus DUT and the status/LED readout.

---
 rtl/or16_chk_pkg.sv | 18 +
 rtl/or16_chk_counter.sv | 24 ++
 rtl/or16_result_checker.sv | 108 ++++++++++
 tb/tb_or16_result_checker.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/or16_chk_pkg.sv
// Shared types, defaults and the reference OR model for the OR16 result checker.
package or16_chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } chk_state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 33;

    function automatic logic [DEF_WIDTH-1:0] or_ref(input logic [DEF_WIDTH-1:0] a,
                                                    input logic [DEF_WIDTH-1:0] b);
        return a | b;
    endfunction

endpackage

// File: rtl/or16_chk_counter.sv
// Up-counter with synchronous clear and enable; optionally sticks at all-ones.
module or16_chk_counter
    import or16_chk_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // With saturation enabled, an all-ones count holds instead of wrapping to zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en && !(SATURATE && (&count))) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/or16_result_checker.sv
// Capture/compare end of the OR16 sweep: checks OUT == A|B per handshake and reports PASS/FAIL.
// Optional macro OR16_CHK_STOP_ON_FAIL_EN ends the run on the first mismatching sample.
module or16_result_checker
    import or16_chk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] total,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_out,
    output logic             fail_valid
);

    chk_state_t       state;
    logic [CNT_W-1:0] total_q;
    logic [WIDTH-1:0] expected;
    logic             accept;
    logic             mismatch;
    logic             last_sample;
    logic             stop_on_fail;

    assign expected    = WIDTH'(or_ref(DEF_WIDTH'(in_a), DEF_WIDTH'(in_b)));
    assign in_ready    = (state == RUN);
    assign busy        = (state == RUN);
    // A start pulse takes priority over a coincident sample, so that sample is dropped.
    assign accept      = in_valid && in_ready && !start;
    assign mismatch    = (in_out != expected);
    assign last_sample = (sample_cnt == total_q - CNT_W'(1));

`ifdef OR16_CHK_STOP_ON_FAIL_EN
    assign stop_on_fail = accept && mismatch;
`else
    assign stop_on_fail = 1'b0;
`endif

    or16_chk_counter #(.CNT_W(CNT_W), .SATURATE(1'b0)) u_sample_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (start),
        .en    (accept),
        .count (sample_cnt)
    );

    or16_chk_counter #(.CNT_W(CNT_W), .SATURATE(1'b1)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (start),
        .en    (accept && mismatch),
        .count (err_cnt)
    );

    // PASS is decided on the finishing edge, folding in a mismatch on that final sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            total_q    <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_out   <= '0;
        end else if (start) begin
            total_q    <= total;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_out   <= '0;
            if (total == '0) begin
                state <= DONE;
                done  <= 1'b1;
                pass  <= 1'b1;
            end else begin
                state <= RUN;
                done  <= 1'b0;
                pass  <= 1'b0;
            end
        end else if (accept) begin
            if (mismatch && !fail_valid) begin
                fail_valid <= 1'b1;
                fail_a     <= in_a;
                fail_b     <= in_b;
                fail_out   <= in_out;
            end
            if (last_sample || stop_on_fail) begin
                state <= DONE;
                done  <= 1'b1;
                pass  <= (err_cnt == '0) && !mismatch;
            end
        end
    end

endmodule

// File: tb/tb_or16_result_checker.sv
// Scoreboard bench for or16_result_checker: expected end-of-run results are queued by the
// stimulus and popped by a monitor whenever DONE rises; plus a 4-bit exhaustive instance.
module tb_or16_result_checker;

    typedef struct {
        string       name;
        logic [32:0] samples;
        logic [32:0] errs;
        logic        pass;
        logic        fvalid;
        logic [15:0] fa;
        logic [15:0] fb;
        logic [15:0] fo;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [32:0] total;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [15:0] in_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [32:0] sample_cnt;
    logic [32:0] err_cnt;
    logic [15:0] fail_a;
    logic [15:0] fail_b;
    logic [15:0] fail_out;
    logic        fail_valid;

    logic        s4_start;
    logic [8:0]  s4_total;
    logic        s4_valid;
    logic        s4_ready;
    logic [3:0]  s4_a;
    logic [3:0]  s4_b;
    logic [3:0]  s4_out;
    logic        s4_busy;
    logic        s4_done;
    logic        s4_pass;
    logic [8:0]  s4_samples;
    logic [8:0]  s4_errs;
    logic [3:0]  s4_fail_a;
    logic [3:0]  s4_fail_b;
    logic [3:0]  s4_fail_out;
    logic        s4_fail_valid;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    logic prevDone = 1'b0;

    or16_result_checker #(.WIDTH(16), .CNT_W(33)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .total      (total),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_out     (in_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .sample_cnt (sample_cnt),
        .err_cnt    (err_cnt),
        .fail_a     (fail_a),
        .fail_b     (fail_b),
        .fail_out   (fail_out),
        .fail_valid (fail_valid)
    );

    or16_result_checker #(.WIDTH(4), .CNT_W(9)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (s4_start),
        .total      (s4_total),
        .in_valid   (s4_valid),
        .in_ready   (s4_ready),
        .in_a       (s4_a),
        .in_b       (s4_b),
        .in_out     (s4_out),
        .busy       (s4_busy),
        .done       (s4_done),
        .pass       (s4_pass),
        .sample_cnt (s4_samples),
        .err_cnt    (s4_errs),
        .fail_a     (s4_fail_a),
        .fail_b     (s4_fail_b),
        .fail_out   (s4_fail_out),
        .fail_valid (s4_fail_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
        end
    endtask

    task automatic pushExp(input string name, input logic [32:0] samples, input logic [32:0] errs,
                           input logic p, input logic fv, input logic [15:0] fa,
                           input logic [15:0] fb, input logic [15:0] fo);
        exp_t e;
        e.name = name; e.samples = samples; e.errs = errs; e.pass = p;
        e.fvalid = fv; e.fa = fa; e.fb = fb; e.fo = fo;
        expQ.push_back(e);
    endtask

    // Monitor: each rising DONE consumes one queued end-of-run expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done && !prevDone) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_done", 64'(done), 64'(0));
            end else begin
                e = expQ.pop_front();
                checkOutput({e.name, "_samples"}, 64'(sample_cnt), 64'(e.samples));
                checkOutput({e.name, "_errs"}, 64'(err_cnt), 64'(e.errs));
                checkOutput({e.name, "_pass"}, 64'(pass), 64'(e.pass));
                checkOutput({e.name, "_fvalid"}, 64'(fail_valid), 64'(e.fvalid));
                checkOutput({e.name, "_fail_a"}, 64'(fail_a), 64'(e.fa));
                checkOutput({e.name, "_fail_b"}, 64'(fail_b), 64'(e.fb));
                checkOutput({e.name, "_fail_out"}, 64'(fail_out), 64'(e.fo));
            end
        end
        prevDone = done;
    end

    task automatic startRun(input logic [32:0] t);
        start = 1'b1;
        total = t;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [15:0] o);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checkOutput("ready_timeout", 64'(in_ready), 64'(1));
        end else begin
            in_a = a; in_b = b; in_out = o; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk);
        checkOutput({name, "_done_reached"}, 64'(done), 64'(1));
        @(posedge clk); #1;
    endtask

    task automatic checkIdle(input string tag);
        @(negedge clk);
        checkOutput({tag, "_done"}, 64'(done), 64'(0));
        checkOutput({tag, "_pass"}, 64'(pass), 64'(0));
        checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
        checkOutput({tag, "_ready"}, 64'(in_ready), 64'(0));
        checkOutput({tag, "_samples"}, 64'(sample_cnt), 64'(0));
        checkOutput({tag, "_errs"}, 64'(err_cnt), 64'(0));
        checkOutput({tag, "_fail"}, {15'd0, fail_valid, fail_a, fail_b, fail_out}, 64'(0));
    endtask

    initial begin
        int accepted;
        logic ok;
        logic earlyDone;
        logic readySeen;

        rst = 1'b1; start = 1'b0; total = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_out = '0;
        s4_start = 1'b0; s4_total = '0; s4_valid = 1'b0; s4_a = '0; s4_b = '0; s4_out = '0;
        repeat (3) @(posedge clk);
        #1;
        checkIdle("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a run aborts with everything cleared.
        startRun(33'd10);
        for (int i = 0; i < 5; i++) applyStimulus(16'(i), 16'(i * 3), 16'(i | (i * 3)));
        @(negedge clk);
        checkOutput("midrun_samples", 64'(sample_cnt), 64'(5));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checkIdle("midrun_reset");
        rst = 1'b0;
        @(posedge clk); #1;

        pushExp("clean4", 33'd4, 33'd0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
        startRun(33'd4);
        applyStimulus(16'h0000, 16'h0000, 16'h0000);
        applyStimulus(16'hFFFF, 16'h0000, 16'hFFFF);
        applyStimulus(16'h00F0, 16'h0F00, 16'h0FF0);
        applyStimulus(16'h8001, 16'h0001, 16'h8001);
        @(negedge clk);
        checkOutput("clean4_done_next_cycle", 64'(done), 64'(1));
        waitDone("clean4");

`ifdef OR16_CHK_STOP_ON_FAIL_EN
        pushExp("mism3", 33'd2, 33'd1, 1'b0, 1'b1, 16'h1234, 16'h0001, 16'h1234);
`else
        pushExp("mism3", 33'd3, 33'd2, 1'b0, 1'b1, 16'h1234, 16'h0001, 16'h1234);
`endif
        startRun(33'd3);
        applyStimulus(16'h0003, 16'h0004, 16'h0007);
        applyStimulus(16'h1234, 16'h0001, 16'h1234);
`ifndef OR16_CHK_STOP_ON_FAIL_EN
        applyStimulus(16'h0001, 16'h0002, 16'h0000);
`endif
        waitDone("mism3");

        // Restart during RUN with a coincident valid sample: that sample must be dropped.
        startRun(33'd5);
        applyStimulus(16'h0011, 16'h0022, 16'h0033);
        applyStimulus(16'h0100, 16'h0200, 16'h0300);
        pushExp("restart", 33'd2, 33'd0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
        in_a = 16'hAAAA; in_b = 16'h5555; in_out = 16'hFFFF; in_valid = 1'b1;
        startRun(33'd2);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("restart_samples_cleared", 64'(sample_cnt), 64'(0));
        checkOutput("restart_busy", 64'(busy), 64'(1));
        @(posedge clk); #1;
        applyStimulus(16'h0F0F, 16'hF0F0, 16'hFFFF);
        applyStimulus(16'h1000, 16'h0001, 16'h1001);
        waitDone("restart");

        // Zero-length run finishes immediately and never raises ready.
        readySeen = 1'b0;
        in_valid = 1'b1;
        startRun(33'd0);
        for (int i = 0; i < 4; i++) begin
            readySeen |= in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("zero_done", 64'(done), 64'(1));
        checkOutput("zero_pass", 64'(pass), 64'(1));
        checkOutput("zero_samples", 64'(sample_cnt), 64'(0));
        checkOutput("zero_ready_never", 64'(readySeen), 64'(0));
        @(posedge clk); #1;

        pushExp("rand100", 33'd100, 33'd0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
        startRun(33'd100);
        accepted = 0;
        earlyDone = 1'b0;
        for (int cyc = 0; cyc < 2000 && accepted < 100; cyc++) begin
            in_valid = 1'($urandom % 2);
            in_a = 16'($urandom);
            in_b = 16'($urandom);
            in_out = in_a | in_b;
            ok = in_valid && in_ready;
            @(posedge clk); #1;
            if (ok) accepted++;
            if (accepted < 100 && done) earlyDone = 1'b1;
        end
        checkOutput("rand_accepted", 64'(accepted), 64'(100));
        checkOutput("rand_no_early_done", 64'(earlyDone), 64'(0));
        checkOutput("rand_done_after_100", 64'(done), 64'(1));
        in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("rand_extra_ignored", 64'(sample_cnt), 64'(100));
        @(posedge clk); #1;

        // Exhaustive 4-bit sweep on the narrow instance.
        s4_total = 9'd256;
        s4_start = 1'b1;
        @(posedge clk); #1;
        s4_start = 1'b0;
        accepted = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                s4_a = 4'(a); s4_b = 4'(b); s4_out = 4'(a | b); s4_valid = 1'b1;
                ok = s4_ready;
                @(posedge clk); #1;
                if (ok) accepted++;
            end
        end
        s4_valid = 1'b0;
        @(negedge clk);
        checkOutput("w4_accepted", 64'(accepted), 64'(256));
        checkOutput("w4_done", 64'(s4_done), 64'(1));
        checkOutput("w4_pass", 64'(s4_pass), 64'(1));
        checkOutput("w4_samples", 64'(s4_samples), 64'(256));
        checkOutput("w4_errs", 64'(s4_errs), 64'(0));

        @(posedge clk); #1;
        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
